// File: rtl/parking_gate_controller.sv
// Eight-slot parking gate controller: arbitrates entry/exit requests, tracks slot
// occupancy and holds the barrier open for GATE_CYCLES cycles per granted car.
module parking_gate_controller #(
    parameter int GATE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       entry_req,
    input  logic       exit_req,
    input  logic [2:0] exit_slot,
    output logic [7:0] occupancy,
    output logic [3:0] parked_count,
    output logic [3:0] empty_count,
    output logic       full,
    output logic       entry_grant,
    output logic       exit_grant,
    output logic [2:0] grant_slot,
    output logic       gate_open,
    output logic       deny
);

    typedef enum logic [1:0] {IDLE, ENTRY_OPEN, EXIT_OPEN} state_t;

    state_t     state_q, state_d;
    logic [3:0] timer_q, timer_d;
    logic [7:0] occ_q, occ_d;
    logic       last_exit_q, last_exit_d;   // 1: last served request was an exit
    logic [2:0] slot_q, slot_d;
    logic       gate_q, gate_d;
    logic       eg_q, eg_d;
    logic       xg_q, xg_d;
    logic       deny_q, deny_d;

    logic [2:0] free_idx;
    logic [3:0] cnt;
    logic       serve_exit;

    always_comb begin
        free_idx = '0;
        for (int i = 7; i >= 0; i--)
            if (!occ_q[i]) free_idx = 3'(i);
    end

    always_comb begin
        cnt = '0;
        for (int i = 0; i < 8; i++)
            cnt = cnt + {3'b000, occ_q[i]};
    end

    // On a tie, alternate away from whichever type was served last
    assign serve_exit = exit_req && (!entry_req || !last_exit_q);

    always_comb begin
        state_d     = state_q;
        timer_d     = timer_q;
        occ_d       = occ_q;
        last_exit_d = last_exit_q;
        slot_d      = slot_q;
        gate_d      = gate_q;
        eg_d        = 1'b0;
        xg_d        = 1'b0;
        deny_d      = 1'b0;
        case (state_q)
            IDLE: begin
                gate_d = 1'b0;
                if (serve_exit) begin
                    last_exit_d = 1'b1;
                    if (occ_q[exit_slot]) begin
                        occ_d[exit_slot] = 1'b0;
                        state_d          = EXIT_OPEN;
                        slot_d           = exit_slot;
                        xg_d             = 1'b1;
                        gate_d           = 1'b1;
                        timer_d          = 4'(GATE_CYCLES - 1);
                    end else begin
                        deny_d = 1'b1;
                    end
                end else if (entry_req) begin
                    last_exit_d = 1'b0;
                    if (&occ_q) begin
                        deny_d = 1'b1;
                    end else begin
                        occ_d[free_idx] = 1'b1;
                        state_d         = ENTRY_OPEN;
                        slot_d          = free_idx;
                        eg_d            = 1'b1;
                        gate_d          = 1'b1;
                        timer_d         = 4'(GATE_CYCLES - 1);
                    end
                end
            end
            ENTRY_OPEN, EXIT_OPEN: begin
                if (timer_q == 4'd0) begin
                    state_d = IDLE;
                    gate_d  = 1'b0;
                end else begin
                    timer_d = timer_q - 4'd1;
                end
            end
            default: begin
                state_d = IDLE;
                gate_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            timer_q     <= '0;
            occ_q       <= '0;
            last_exit_q <= 1'b0;
            slot_q      <= '0;
            gate_q      <= 1'b0;
            eg_q        <= 1'b0;
            xg_q        <= 1'b0;
            deny_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            occ_q       <= occ_d;
            last_exit_q <= last_exit_d;
            slot_q      <= slot_d;
            gate_q      <= gate_d;
            eg_q        <= eg_d;
            xg_q        <= xg_d;
            deny_q      <= deny_d;
        end
    end

    assign occupancy    = occ_q;
    assign parked_count = cnt;
    assign empty_count  = 4'd8 - cnt;
    assign full         = &occ_q;
    assign entry_grant  = eg_q;
    assign exit_grant   = xg_q;
    assign grant_slot   = slot_q;
    assign gate_open    = gate_q;
    assign deny         = deny_q;

endmodule

// File: tb/tb_parking_gate_controller.sv
// Bench for parking_gate_controller: vector table, directed corner sequences,
// and a randomized run against a slot-array reference model.
module tb_parking_gate_controller;

    localparam int GC = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       entry_req = 1'b0;
    logic       exit_req = 1'b0;
    logic [2:0] exit_slot = '0;
    logic [7:0] occupancy;
    logic [3:0] parked_count, empty_count;
    logic       full, entry_grant, exit_grant, gate_open, deny;
    logic [2:0] grant_slot;

    int n_cmp = 0;
    int n_err = 0;

    parking_gate_controller #(.GATE_CYCLES(GC)) dut (
        .clk(clk), .rst(rst), .entry_req(entry_req), .exit_req(exit_req),
        .exit_slot(exit_slot), .occupancy(occupancy), .parked_count(parked_count),
        .empty_count(empty_count), .full(full), .entry_grant(entry_grant),
        .exit_grant(exit_grant), .grant_slot(grant_slot), .gate_open(gate_open),
        .deny(deny)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_counts(input string tag, input logic [7:0] exp_occ);
        chk({tag, ".occ"}, 32'(occupancy), 32'(exp_occ));
        chk({tag, ".parked"}, 32'(parked_count), 32'($countones(exp_occ)));
        chk({tag, ".empty"}, 32'(empty_count), 32'(8 - $countones(exp_occ)));
        chk({tag, ".full"}, 32'(full), 32'(exp_occ == 8'hFF));
    endtask

    task automatic do_reset();
        rst = 1'b1; entry_req = 1'b0; exit_req = 1'b0; exit_slot = '0;
        tick();
        rst = 1'b0;
    endtask

    // Wait (bounded) until the gate has closed and the FSM is back in IDLE
    task automatic wait_closed(input string tag);
        int n = 0;
        while (gate_open === 1'b1 && n < 40) begin
            tick();
            n++;
        end
        chk({tag, ".gate_close_timeout"}, 32'(gate_open === 1'b1), 32'd0);
    endtask

    task automatic enter_one(input string tag);
        entry_req = 1'b1;
        tick();
        entry_req = 1'b0;
        chk({tag, ".eg"}, 32'(entry_grant), 32'd1);
        wait_closed(tag);
    endtask

    typedef struct {
        logic       r, e, x;
        logic [2:0] s;
        logic [7:0] occ;
        logic       eg, xg, dn, go;
        logic [2:0] gs;
    } vec_t;

    vec_t vt[13];

    // Reference model state
    bit       m_occ[8];
    bit       m_last_exit;
    int       m_remain;
    bit       m_eg, m_xg, m_dn, m_go;
    int       m_gs;

    function automatic logic [7:0] m_occ_vec();
        logic [7:0] v;
        for (int i = 0; i < 8; i++) v[i] = m_occ[i];
        return v;
    endfunction

    task automatic model_step(input bit r, input bit e, input bit x, input int s);
        int k;
        bit have_free;
        m_eg = 0; m_xg = 0; m_dn = 0;
        if (r) begin
            foreach (m_occ[i]) m_occ[i] = 0;
            m_last_exit = 0; m_remain = 0; m_go = 0; m_gs = 0;
        end else if (m_remain > 0) begin
            m_remain--;
            m_go = (m_remain > 0);
        end else begin
            m_go = 0;
            if (x && (!e || !m_last_exit)) begin
                m_last_exit = 1;
                if (m_occ[s]) begin
                    m_occ[s] = 0; m_xg = 1; m_gs = s; m_go = 1; m_remain = GC;
                end else m_dn = 1;
            end else if (e) begin
                m_last_exit = 0;
                have_free = 0; k = 0;
                for (int i = 7; i >= 0; i--) if (!m_occ[i]) begin have_free = 1; k = i; end
                if (!have_free) m_dn = 1;
                else begin
                    m_occ[k] = 1; m_eg = 1; m_gs = k; m_go = 1; m_remain = GC;
                end
            end
        end
    endtask

    initial begin
        //          r  e  x  s   occ    eg xg dn go gs
        vt[0]  = '{1, 0, 0, 0, 8'h00, 0, 0, 0, 0, 0};
        vt[1]  = '{0, 1, 0, 0, 8'h01, 1, 0, 0, 1, 0};
        vt[2]  = '{0, 0, 0, 0, 8'h01, 0, 0, 0, 1, 0};
        vt[3]  = '{0, 0, 0, 0, 8'h01, 0, 0, 0, 1, 0};
        vt[4]  = '{0, 0, 0, 0, 8'h01, 0, 0, 0, 1, 0};
        vt[5]  = '{0, 0, 0, 0, 8'h01, 0, 0, 0, 0, 0};
        vt[6]  = '{0, 0, 1, 6, 8'h01, 0, 0, 1, 0, 0};
        vt[7]  = '{0, 0, 0, 0, 8'h01, 0, 0, 0, 0, 0};
        // tie after an exit deny: entry wins, takes slot 1
        vt[8]  = '{0, 1, 1, 0, 8'h03, 1, 0, 0, 1, 1};
        vt[9]  = '{0, 1, 1, 0, 8'h03, 0, 0, 0, 1, 1};
        vt[10] = '{0, 0, 0, 0, 8'h03, 0, 0, 0, 1, 1};
        vt[11] = '{0, 0, 0, 0, 8'h03, 0, 0, 0, 1, 1};
        vt[12] = '{0, 0, 0, 0, 8'h03, 0, 0, 0, 0, 1};

        for (int i = 0; i < 13; i++) begin
            string t;
            t = $sformatf("vec%0d", i);
            rst = vt[i].r; entry_req = vt[i].e; exit_req = vt[i].x; exit_slot = vt[i].s;
            tick();
            chk_counts(t, vt[i].occ);
            chk({t, ".eg"}, 32'(entry_grant), 32'(vt[i].eg));
            chk({t, ".xg"}, 32'(exit_grant), 32'(vt[i].xg));
            chk({t, ".deny"}, 32'(deny), 32'(vt[i].dn));
            chk({t, ".gate"}, 32'(gate_open), 32'(vt[i].go));
            if (vt[i].go || vt[i].r) chk({t, ".gs"}, 32'(grant_slot), 32'(vt[i].gs));
        end

        // Fill all eight slots, then a ninth entry is denied
        do_reset();
        for (int i = 0; i < 8; i++) enter_one($sformatf("fill%0d", i));
        chk_counts("filled", 8'hFF);
        entry_req = 1'b1;
        tick();
        entry_req = 1'b0;
        chk("ninth.deny", 32'(deny), 32'd1);
        chk("ninth.gate", 32'(gate_open), 32'd0);
        chk_counts("ninth", 8'hFF);
        tick();
        chk("ninth.deny_pulse", 32'(deny), 32'd0);

        // From full: free slot 5, the next entry must reuse it
        exit_req = 1'b1; exit_slot = 3'd5;
        tick();
        exit_req = 1'b0;
        chk("ex5.xg", 32'(exit_grant), 32'd1);
        chk("ex5.gs", 32'(grant_slot), 32'd5);
        chk_counts("ex5", 8'hDF);
        wait_closed("ex5");
        entry_req = 1'b1;
        tick();
        entry_req = 1'b0;
        chk("re5.eg", 32'(entry_grant), 32'd1);
        chk("re5.gs", 32'(grant_slot), 32'd5);
        chk_counts("re5", 8'hFF);
        wait_closed("re5");

        // Tie from reset: exit first, then the still-held entry
        do_reset();
        enter_one("tie_a");
        enter_one("tie_b");
        chk_counts("tie_pre", 8'h03);
        entry_req = 1'b1; exit_req = 1'b1; exit_slot = 3'd1;
        tick();
        chk("tie.xg", 32'(exit_grant), 32'd1);
        chk("tie.eg0", 32'(entry_grant), 32'd0);
        chk_counts("tie_ex", 8'h01);
        exit_req = 1'b0;
        begin
            int n = 0;
            while (entry_grant !== 1'b1 && n < 20) begin tick(); n++; end
            chk("tie.eg_seen", 32'(entry_grant), 32'd1);
            chk("tie.eg_latency", 32'(n), 32'(GC + 1));
        end
        entry_req = 1'b0;
        chk("tie.gs", 32'(grant_slot), 32'd1);
        chk_counts("tie_en", 8'h03);
        wait_closed("tie_en");

        // Reset in the second cycle of an open gate
        do_reset();
        entry_req = 1'b1;
        tick();
        entry_req = 1'b0;
        tick();
        chk("mid.gate2", 32'(gate_open), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid.gate", 32'(gate_open), 32'd0);
        chk("mid.gs", 32'(grant_slot), 32'd0);
        chk_counts("mid", 8'h00);

        // Randomized run against the reference model
        for (int c = 0; c < 3000; c++) begin
            bit r, e, x;
            int s;
            r = (c == 0) || ($urandom_range(0, 199) == 0);
            e = ($urandom_range(0, 2) != 0);
            x = ($urandom_range(0, 2) != 0);
            s = $urandom_range(0, 7);
            rst = r; entry_req = e; exit_req = x; exit_slot = 3'(s);
            tick();
            model_step(r, e, x, s);
            if (occupancy !== m_occ_vec() || entry_grant !== m_eg || exit_grant !== m_xg ||
                deny !== m_dn || gate_open !== m_go || (m_go && grant_slot !== 3'(m_gs)) ||
                parked_count !== 4'($countones(m_occ_vec())) ||
                empty_count !== 4'(8 - $countones(m_occ_vec())) ||
                full !== (m_occ_vec() == 8'hFF)) begin
                n_cmp++;
                n_err++;
                $display("FAIL rand%0d: got occ=%h eg=%b xg=%b dn=%b go=%b gs=%0d pc=%0d, expected occ=%h eg=%b xg=%b dn=%b go=%b gs=%0d",
                         c, occupancy, entry_grant, exit_grant, deny, gate_open, grant_slot,
                         parked_count, m_occ_vec(), m_eg, m_xg, m_dn, m_go, m_gs);
            end else begin
                n_cmp++;
            end
        end
        rst = 1'b0; entry_req = 1'b0; exit_req = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/parking_gate_controller.md
PARKING_GATE_CONTROLLER -- requirements
Module: parking_gate_controller

Interface
REQ-001 Parameter GATE_CYCLES, default 4, meaning the number of cycles gate_open stays high per granted car; the legal range SHALL be 1..15.
REQ-002 Port clk, input, 1 bit: the single clock; all state SHALL update on the rising edge.
REQ-003 Port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 Port entry_req, input, 1 bit: a car requests entry; the signal is level-sensitive.
REQ-005 Port exit_req, input, 1 bit: a car requests exit; the signal is level-sensitive.
REQ-006 Port exit_slot, input, 3 bits: the slot being vacated; it SHALL be valid while exit_req is high.
REQ-007 Port occupancy, output, 8 bits: bit i = 1 means slot i is occupied (registered).
REQ-008 Port parked_count, output, 4 bits: the number of ones in occupancy, range 0..8.
REQ-009 Port empty_count, output, 4 bits: 8 - parked_count.
REQ-010 Port full, output, 1 bit: high when occupancy = 8'hFF.
REQ-011 Port entry_grant, output, 1 bit: a one-cycle pulse when an entry is accepted.
REQ-012 Port exit_grant, output, 1 bit: a one-cycle pulse when an exit is accepted.
REQ-013 Port grant_slot, output, 3 bits: the slot allocated or freed; it SHALL be valid while gate_open is high.
REQ-014 Port gate_open, output, 1 bit: the barrier-open command.
REQ-015 Port deny, output, 1 bit: a one-cycle pulse when a request is rejected.

Function
REQ-016 The FSM SHALL have exactly three states: IDLE, ENTRY_OPEN and EXIT_OPEN.
REQ-017 Requests SHALL be sampled only in IDLE; requests arriving in any other state SHALL be ignored until the FSM returns to IDLE.
REQ-018 In IDLE, the request to serve SHALL be chosen as follows:
- Only one request valid: serve that request.
- Both requests valid: serve the type opposite to last_served (a 1-bit register).
- After reset, last_served SHALL indicate entry, so exit wins the first tie.
REQ-019 When an entry is served and full=0, the following SHALL happen on that edge:
- state -> ENTRY_OPEN
- occupancy bit k set, where k is the lowest-index free slot
- grant_slot = k, entry_grant = 1, gate_open = 1
- timer loaded with GATE_CYCLES-1
- last_served = entry
REQ-020 When an entry is served and full=1, the following SHALL happen:
- deny = 1 for one cycle
- the state stays IDLE
- occupancy is unchanged
- last_served = entry
REQ-021 When an exit is served and occupancy[exit_slot]=1, the following SHALL happen on that edge:
- state -> EXIT_OPEN
- that occupancy bit cleared
- grant_slot = exit_slot, exit_grant = 1, gate_open = 1
- timer loaded with GATE_CYCLES-1
- last_served = exit
REQ-022 When an exit is served and occupancy[exit_slot]=0, deny SHALL pulse for one cycle, the state SHALL stay IDLE, occupancy SHALL be unchanged, and last_served SHALL become exit.
REQ-023 In ENTRY_OPEN and EXIT_OPEN, the timer SHALL decrement each cycle; on the edge where the timer = 0, the state SHALL go to IDLE and gate_open SHALL go to 0, so gate_open is high for exactly GATE_CYCLES cycles.
REQ-024 Latency: a request valid in IDLE before edge N SHALL produce grant/deny and updated occupancy visible after edge N; an IDLE cycle SHALL always separate two services.
REQ-025 entry_grant, exit_grant and deny SHALL be mutually exclusive and registered, and each SHALL be high for one cycle only.
REQ-026 parked_count, empty_count and full SHALL be combinational from occupancy; parked_count + empty_count SHALL equal 8 at all times.
REQ-027 A requester SHALL deassert its request on grant or deny; a request still held on return to IDLE SHALL be treated as a new request.
REQ-028 Occupancy SHALL change only on grant edges.

Reset
REQ-029 When rst=1 at a clock edge, the following SHALL hold after that edge, regardless of state, including mid-gate:
- state = IDLE, timer = 0, last_served = entry
- occupancy = 8'h00
- gate_open = 0, entry_grant = 0, exit_grant = 0, deny = 0
- grant_slot = 0
- parked_count = 0, empty_count = 8, full = 0

Verification
REQ-030 A bench SHALL apply reset, then hold entry_req for one cycle, and check:
- entry_grant pulses once, grant_slot = 0, occupancy = 8'h01
- gate_open high for exactly 4 cycles
- parked_count = 1, empty_count = 7
REQ-031 A bench SHALL perform 8 sequential entries, then one more entry request, and check:
- occupancy = 8'hFF, full = 1, parked_count = 8, empty_count = 0
- the ninth request gives deny pulsing, gate_open staying 0, and occupancy staying 8'hFF
REQ-032 A bench SHALL start from occupancy = 8'hFF, request exit with exit_slot = 5, then request entry, and check:
- after the exit: exit_grant pulses, occupancy = 8'hDF
- the following entry receives grant_slot = 5
REQ-033 A bench SHALL start from reset with occupancy = 8'h03 and raise entry_req and exit_req (exit_slot = 1) on the same cycle, and check:
- exit is served first, giving occupancy = 8'h01
- after return to IDLE with both requests still held, entry is served, giving grant_slot = 1 and occupancy = 8'h03
REQ-034 A bench SHALL request exit with exit_slot = 6 while occupancy = 8'h01 and check that deny pulses and occupancy is unchanged.
REQ-035 A bench SHALL assert rst during the second cycle of gate_open and check that on the next cycle gate_open = 0, occupancy = 8'h00 and empty_count = 8.
